// File: rtl/mem_access.sv
// Load/store unit front end: aligns one memory operation onto a single-beat data bus
// and returns the extended load result or a misalignment fault.
package mem_access_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module mem_access
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output dbus_req_t         dreq,
    input  dbus_resp_t        dresp,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_misalign,
    output logic [1:0]        o_dbg_state
);
    localparam int OFF_W  = $clog2(DATA_W / 8);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              w_accept;
    logic [OFF_W-1:0]  w_off;
    logic [2:0]        w_align_mask;
    logic [7:0]        w_byte_mask;
    logic              w_misalign;
    logic [STRB_W-1:0] w_strobe;
    logic [DATA_W-1:0] w_wdata_sh;
    logic [DATA_W-1:0] w_bus_sh;
    logic [63:0]       w_sh64;
    logic [63:0]       w_ext;
    logic              w_unused;

    logic              r_write;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [ADDR_W-1:0] r_addr;
    logic [OFF_W-1:0]  r_off;
    logic [DATA_W-1:0] r_data;
    logic [STRB_W-1:0] r_strobe;
    logic              r_misalign;
    logic [DATA_W-1:0] r_rdata;

    assign w_accept = req_valid && req_ready;
    assign w_off    = req_addr[OFF_W-1:0];

    always_comb begin
        w_align_mask = 3'b000;
        w_byte_mask  = 8'h01;
        case (req_size)
            2'd0: begin w_align_mask = 3'b000; w_byte_mask = 8'h01; end
            2'd1: begin w_align_mask = 3'b001; w_byte_mask = 8'h03; end
            2'd2: begin w_align_mask = 3'b011; w_byte_mask = 8'h0F; end
            2'd3: begin w_align_mask = 3'b111; w_byte_mask = 8'hFF; end
        endcase
    end

    // A double on a 32-bit path has no legal alignment, so it faults like a misaligned access.
    assign w_misalign = (|(req_addr[2:0] & w_align_mask)) ||
                        ((DATA_W == 32) && (req_size == 2'd3));
    assign w_strobe   = STRB_W'(w_byte_mask) << w_off;
    assign w_wdata_sh = req_wdata << {w_off, 3'b000};

    assign w_bus_sh = dresp.data[DATA_W-1:0] >> {r_off, 3'b000};
    assign w_sh64   = 64'(w_bus_sh);

    always_comb begin
        w_ext = '0;
        case (r_size)
            2'd0: w_ext = r_unsigned ? {56'b0, w_sh64[7:0]}  : {{56{w_sh64[7]}},  w_sh64[7:0]};
            2'd1: w_ext = r_unsigned ? {48'b0, w_sh64[15:0]} : {{48{w_sh64[15]}}, w_sh64[15:0]};
            2'd2: w_ext = r_unsigned ? {32'b0, w_sh64[31:0]} : {{32{w_sh64[31]}}, w_sh64[31:0]};
            2'd3: w_ext = w_sh64;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = w_misalign ? DONE : BUS;
            BUS:  if (dresp.data_ok) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_strobe   <= '0;
            r_misalign <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_misalign <= w_misalign;
                r_strobe   <= (req_write && !w_misalign) ? w_strobe : '0;
                r_rdata    <= '0;
            end else if ((r_state == BUS) && dresp.data_ok && !r_write) begin
                r_rdata <= w_ext[DATA_W-1:0];
            end
        end
    end

    // Request fields need no reset: they are only observed while the FSM is out of IDLE.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_write    <= req_write;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_off      <= w_off;
            r_data     <= req_write ? w_wdata_sh : '0;
        end
    end

    always_comb begin
        dreq        = '0;
        dreq.valid  = (r_state == BUS);
        dreq.addr   = 64'(r_addr);
        dreq.size   = {1'b0, r_size};
        dreq.strobe = 8'(r_strobe);
        dreq.data   = 64'(r_data);
    end

    assign req_ready     = (r_state == IDLE);
    assign resp_valid    = (r_state == DONE);
    assign resp_misalign = (r_state == DONE) && r_misalign;
    assign resp_rdata    = r_rdata;
    assign o_dbg_state   = r_state;

    // Bus handshake completes on data_ok alone; addr_ok carries no information here.
    assign w_unused = ^{dresp.addr_ok, dresp.data, w_ext};
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: 64-bit and 32-bit instances, scoreboard-checked responses.
module tb_mem_access;
    import mem_access_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // 64-bit instance
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;
    logic        resp_valid, resp_misalign;
    logic [63:0] resp_rdata;
    logic [1:0]  dbg_state;

    // 32-bit instance
    logic        req_valid32, req_ready32, req_write32, req_unsigned32;
    logic [1:0]  req_size32;
    logic [31:0] req_addr32, req_wdata32;
    dbus_req_t   dreq32;
    dbus_resp_t  dresp32;
    logic        resp_valid32, resp_misalign32;
    logic [31:0] resp_rdata32;
    logic [1:0]  dbg_state32;

    int total = 0;
    int bad   = 0;
    logic [64:0] exp_q[$];
    logic [32:0] exp32_q[$];

    mem_access #(.DATA_W(64), .ADDR_W(64)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .dreq(dreq), .dresp(dresp),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misalign(resp_misalign), .o_dbg_state(dbg_state)
    );

    mem_access #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid32), .req_ready(req_ready32), .req_write(req_write32),
        .req_size(req_size32), .req_unsigned(req_unsigned32), .req_addr(req_addr32),
        .req_wdata(req_wdata32), .dreq(dreq32), .dresp(dresp32),
        .resp_valid(resp_valid32), .resp_rdata(resp_rdata32),
        .resp_misalign(resp_misalign32), .o_dbg_state(dbg_state32)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    // Response monitors: every completion pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [64:0] e;
        if (resp_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL resp64_unexpected: got mis=%b rdata=%h want no response",
                         resp_misalign, resp_rdata);
            end else begin
                e = exp_q.pop_front();
                if ({resp_misalign, resp_rdata} !== e) begin
                    bad++;
                    $display("FAIL resp64: got mis=%b rdata=%h want mis=%b rdata=%h",
                             resp_misalign, resp_rdata, e[64], e[63:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [32:0] e;
        if (resp_valid32) begin
            total++;
            if (exp32_q.size() == 0) begin
                bad++;
                $display("FAIL resp32_unexpected: got mis=%b rdata=%h want no response",
                         resp_misalign32, resp_rdata32);
            end else begin
                e = exp32_q.pop_front();
                if ({resp_misalign32, resp_rdata32} !== e) begin
                    bad++;
                    $display("FAIL resp32: got mis=%b rdata=%h want mis=%b rdata=%h",
                             resp_misalign32, resp_rdata32, e[32], e[31:0]);
                end
            end
        end
    end

    // Issues one operation on the 64-bit instance and plays the bus side; called at a negedge.
    task automatic run_op(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wd,
                          input logic [63:0] bus, input int dly,
                          input logic mis, input logic [63:0] rd,
                          input logic [7:0] strb, input logic [63:0] bdata);
        check("ready_before", req_ready, 1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        exp_q.push_back({mis, rd});
        @(negedge clk);
        // Scramble inputs so any late sampling of them shows up on the bus.
        req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wd; req_size = ~sz;
        if (mis) begin
            check("mis_no_bus", dreq.valid, 0);
            check("mis_resp_n1", resp_valid, 1);
            check("mis_flag", resp_misalign, 1);
            @(negedge clk);
            check("mis_pulse_end", resp_valid, 0);
            check("mis_ready_back", req_ready, 1);
        end else begin
            for (int i = 0; i <= dly; i++) begin
                check("bus_valid", dreq.valid, 1);
                check("bus_addr", dreq.addr, addr);
                check("bus_size", dreq.size, {1'b0, sz});
                check("bus_strobe", dreq.strobe, strb);
                check("bus_data", dreq.data, bdata);
                check("bus_not_ready", req_ready, 0);
                check("bus_no_resp", resp_valid, 0);
                dresp.addr_ok = (i == 0);
                dresp.data_ok = (i == dly);
                dresp.data    = (i == dly) ? bus : ~bus;
                @(negedge clk);
            end
            dresp = '0;
            check("done_valid_drop", dreq.valid, 0);
            check("done_resp", resp_valid, 1);
            check("done_not_ready", req_ready, 0);
            @(negedge clk);
            check("done_pulse_end", resp_valid, 0);
            check("done_ready_back", req_ready, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
        dresp = '0;
        req_valid32 = 0; req_write32 = 0; req_size32 = 0; req_unsigned32 = 0;
        req_addr32 = 0; req_wdata32 = 0;
        dresp32 = '0;
        repeat (3) @(negedge clk);

        check("rst_ready", req_ready, 1);
        check("rst_dreq_valid", dreq.valid, 0);
        check("rst_strobe", dreq.strobe, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_misalign", resp_misalign, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_state", dbg_state, 0);
        check("rst32_ready", req_ready32, 1);
        check("rst32_rdata", resp_rdata32, 0);
        reset = 1'b0;
        @(negedge clk);

        // wr sz uns addr wdata bus dly mis rdata strobe bus_data
        run_op(1, 2'd0, 0, 64'h1003, 64'hAB, 64'h0, 0, 0, 64'h0, 8'h08, 64'hAB00_0000);
        run_op(0, 2'd1, 0, 64'h2006, 64'h0, 64'h8001_0000_0000_0000, 1, 0,
               64'hFFFF_FFFF_FFFF_8001, 8'h00, 64'h0);
        run_op(0, 2'd1, 1, 64'h2006, 64'h0, 64'h8001_0000_0000_0000, 0, 0,
               64'h0000_0000_0000_8001, 8'h00, 64'h0);
        run_op(0, 2'd2, 0, 64'h3002, 64'h0, 64'h0, 0, 1, 64'h0, 8'h00, 64'h0);
        run_op(1, 2'd2, 0, 64'h14, 64'h1234_5678, 64'h0, 5, 0, 64'h0, 8'hF0,
               64'h1234_5678_0000_0000);
        run_op(0, 2'd3, 0, 64'h8, 64'h0, 64'hDEAD_BEEF_0123_4567, 2, 0,
               64'hDEAD_BEEF_0123_4567, 8'h00, 64'h0);
        run_op(0, 2'd0, 0, 64'h5, 64'h0, 64'h1122_99FF_3344_5566, 0, 0,
               64'hFFFF_FFFF_FFFF_FF99, 8'h00, 64'h0);
        run_op(1, 2'd1, 0, 64'h1001, 64'hBEEF, 64'h0, 0, 1, 64'h0, 8'h00, 64'h0);
        run_op(1, 2'd3, 0, 64'h18, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0, 64'h0, 8'hFF,
               64'h0123_4567_89AB_CDEF);

        // data_ok while idle must be ignored
        dresp.data_ok = 1'b1; dresp.data = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        dresp = '0;
        check("idle_dataok_ready", req_ready, 1);
        check("idle_dataok_valid", dreq.valid, 0);
        check("idle_dataok_resp", resp_valid, 0);

        // Reset two cycles into BUS, colliding with data_ok and a new request
        req_valid = 1'b1; req_write = 0; req_size = 2'd2; req_unsigned = 0; req_addr = 64'h20;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_in_bus", dreq.valid, 1);
        reset = 1'b1; dresp.data_ok = 1'b1; dresp.data = 64'h55; req_valid = 1'b1;
        @(negedge clk);
        check("abort_valid_drop", dreq.valid, 0);
        check("abort_no_resp", resp_valid, 0);
        reset = 1'b0; dresp = '0; req_valid = 1'b0;
        @(negedge clk);
        check("abort_ready", req_ready, 1);
        check("abort_no_resp2", resp_valid, 0);
        check("abort_idle_valid", dreq.valid, 0);
        run_op(0, 2'd2, 1, 64'h24, 64'h0, 64'h89AB_CDEF_0000_0000, 0, 0,
               64'h0000_0000_89AB_CDEF, 8'h00, 64'h0);

        // 32-bit instance: double faults
        check("w32_ready", req_ready32, 1);
        req_valid32 = 1'b1; req_write32 = 0; req_size32 = 2'd3; req_addr32 = 32'h0;
        exp32_q.push_back({1'b1, 32'h0});
        @(negedge clk);
        req_valid32 = 1'b0;
        check("w32_dbl_no_bus", dreq32.valid, 0);
        check("w32_dbl_resp", resp_valid32, 1);
        @(negedge clk);

        // 32-bit word load at 0x4004
        req_valid32 = 1'b1; req_write32 = 0; req_size32 = 2'd2; req_unsigned32 = 0;
        req_addr32 = 32'h4004;
        exp32_q.push_back({1'b0, 32'hCAFE_F00D});
        @(negedge clk);
        req_valid32 = 1'b0;
        check("w32_ld_valid", dreq32.valid, 1);
        check("w32_ld_addr", dreq32.addr, 64'h4004);
        check("w32_ld_size", dreq32.size, 3'b010);
        check("w32_ld_strobe", dreq32.strobe, 0);
        dresp32.data_ok = 1'b1; dresp32.data = 64'h1111_2222_CAFE_F00D;
        @(negedge clk);
        dresp32 = '0;
        check("w32_ld_resp", resp_valid32, 1);
        @(negedge clk);

        // 32-bit byte store at offset 2
        req_valid32 = 1'b1; req_write32 = 1; req_size32 = 2'd0; req_addr32 = 32'h4006;
        req_wdata32 = 32'h5A;
        exp32_q.push_back({1'b0, 32'h0});
        @(negedge clk);
        req_valid32 = 1'b0;
        check("w32_st_strobe", dreq32.strobe, 8'h04);
        check("w32_st_data", dreq32.data, 64'h005A_0000);
        dresp32.data_ok = 1'b1;
        @(negedge clk);
        dresp32 = '0;
        check("w32_st_resp", resp_valid32, 1);
        @(negedge clk);
        check("w32_ready_end", req_ready32, 1);

        repeat (3) @(negedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("exp32_q_drained", exp32_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter DATA_W, default 64, data path width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 64, address width in bits.
REQ-003 SHALL have derived constant OFF_W = log2(DATA_W/8), byte-lane offset width.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  1  pipeline offers a memory operation.
REQ-007 SHALL have port req_ready  out  1  block can accept an operation this cycle.
REQ-008 SHALL have port req_write  in  1  1 = store, 0 = load.
REQ-009 SHALL have port req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 double (11 illegal when DATA_W=32).
REQ-010 SHALL have port req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-011 SHALL have port req_addr  in  ADDR_W  byte address.
REQ-012 SHALL have port req_wdata  in  DATA_W  store data, right-aligned.
REQ-013 SHALL have port dreq  out  dbus_req_t  bus request: valid, addr, size, strobe, data.
REQ-014 SHALL have port dresp  in  dbus_resp_t  bus response: addr_ok, data_ok, data.
REQ-015 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-016 SHALL have port resp_rdata  out  DATA_W  load result, extended; 0 for stores.
REQ-017 SHALL have port resp_misalign  out  1  completion is a misalignment fault; no bus access made.

Function
REQ-018 SHALL implement FSM states IDLE, BUS, DONE; req_ready = (state==IDLE).
REQ-019 SHALL accept on req_valid & req_ready; all request fields captured into registers that cycle.
REQ-020 SHALL treat an access as misaligned when addr modulo (1<<req_size) != 0; misaligned -> IDLE to DONE, dreq.valid stays 0, resp_misalign=1.
REQ-021 SHALL, for an aligned access, go IDLE -> BUS; dreq.valid=1 from the cycle after acceptance.
REQ-022 SHALL hold dreq.valid, addr, size, strobe, data stable in BUS until the cycle dresp.data_ok=1, independent of addr_ok.
REQ-023 SHALL drive dreq.addr = captured address unmodified and dreq.size = {1'b0, req_size}.
REQ-024 SHALL compute store strobe = ((1<<(1<<size))-1) << addr[OFF_W-1:0] and data = wdata << (addr[OFF_W-1:0]*8); loads: strobe = 0.
REQ-025 SHALL, on data_ok in BUS, drop dreq.valid next cycle and go BUS -> DONE.
REQ-026 SHALL, for loads, register rdata = extend((dresp.data >> offset*8) truncated to 8<<size bits) at data_ok.
REQ-027 SHALL assert resp_valid for exactly one cycle in DONE, then return to IDLE.
REQ-028 SHALL give aligned latency = acceptance cycle N, bus cycles N+1..M with data_ok at M, resp_valid at M+1, req_ready again at M+2.
REQ-029 SHALL give misaligned latency: resp_valid at N+1.
REQ-030 SHALL ignore dresp.data_ok when not in BUS.
REQ-031 SHALL treat req_size=11 with DATA_W=32 as misaligned, i.e. faulted.

Reset
REQ-032 SHALL, with reset high at a clock edge, go to IDLE and clear dreq.valid, strobe, resp_valid, resp_misalign and resp_rdata to 0.
REQ-033 SHALL, on reset mid-BUS, drop dreq.valid the next cycle and issue no resp_valid for the aborted operation.
REQ-034 SHALL take reset priority over data_ok and req_valid arriving in the same cycle.

Verification
REQ-035 Byte store: addr 0x1003, wdata 0xAB -> strobe 0x08, dreq.data 0xAB000000, resp_valid one cycle after data_ok.
REQ-036 Signed half load: addr 0x2006, bus data 0x8001_0000_0000_0000 -> resp_rdata 0xFFFF_FFFF_FFFF_8001; with unsigned=1 -> 0x8001.
REQ-037 Misaligned word load: addr 0x3002 -> no dreq.valid, resp_valid and resp_misalign at N+1.
REQ-038 Slow bus: data_ok delayed 5 cycles -> dreq fields stable all 5 cycles, req_ready=0 throughout.
REQ-039 Reset asserted two cycles into BUS -> dreq.valid=0 next cycle, no resp_valid, req_ready=1 after reset release.
REQ-040 DATA_W=32 double-size request -> resp_misalign=1; word load at 0x4004 -> strobe 0, rdata from bus bits 31:0.
